// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seven-segment display scanner.
// Segment patterns are active-low with bit6 = a down to bit0 = g.
package seg7_pkg;

  // All segments dark.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Decimal glyphs.
  localparam logic [6:0] FONT_0 = 7'h01;
  localparam logic [6:0] FONT_1 = 7'h4F;
  localparam logic [6:0] FONT_2 = 7'h12;
  localparam logic [6:0] FONT_3 = 7'h06;
  localparam logic [6:0] FONT_4 = 7'h4C;
  localparam logic [6:0] FONT_5 = 7'h24;
  localparam logic [6:0] FONT_6 = 7'h20;
  localparam logic [6:0] FONT_7 = 7'h0F;
  localparam logic [6:0] FONT_8 = 7'h00;
  localparam logic [6:0] FONT_9 = 7'h04;

  // Hex glyphs A, b, C, d, E, F.
  localparam logic [6:0] FONT_A = 7'h08;
  localparam logic [6:0] FONT_B = 7'h60;
  localparam logic [6:0] FONT_C = 7'h31;
  localparam logic [6:0] FONT_D = 7'h42;
  localparam logic [6:0] FONT_E = 7'h30;
  localparam logic [6:0] FONT_F = 7'h38;

  // Everything the scanner needs to remember about one digit position.
  typedef struct packed {
    logic [3:0] value;
    logic       dp;
    logic       blank;
    logic       blink;
  } digit_attr_t;

  // Buffer contents after reset: value 0, no decimal point, dark.
  localparam digit_attr_t DIGIT_RESET = '{value: 4'h0, dp: 1'b0, blank: 1'b1, blink: 1'b0};

  // Map a nibble to its glyph; values 10-15 are blank unless hex is enabled.
  function automatic logic [6:0] seg7_font(input logic [3:0] val, input logic hex_en);
    logic [6:0] seg;
    seg = SEG_OFF;
    case (val)
      4'h0:    seg = FONT_0;
      4'h1:    seg = FONT_1;
      4'h2:    seg = FONT_2;
      4'h3:    seg = FONT_3;
      4'h4:    seg = FONT_4;
      4'h5:    seg = FONT_5;
      4'h6:    seg = FONT_6;
      4'h7:    seg = FONT_7;
      4'h8:    seg = FONT_8;
      4'h9:    seg = FONT_9;
      4'hA:    seg = hex_en ? FONT_A : SEG_OFF;
      4'hB:    seg = hex_en ? FONT_B : SEG_OFF;
      4'hC:    seg = hex_en ? FONT_C : SEG_OFF;
      4'hD:    seg = hex_en ? FONT_D : SEG_OFF;
      4'hE:    seg = hex_en ? FONT_E : SEG_OFF;
      4'hF:    seg = hex_en ? FONT_F : SEG_OFF;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational glyph lookup for one digit value.
module seven_segment_decoder
  import seg7_pkg::*;
#(
  parameter bit HEX_EN = 1'b1
) (
  input  logic [3:0] value_i,
  output logic [6:0] segments_o
);

  // Pure font lookup; the scanner registers the result before it reaches a pin.
  always_comb begin
    segments_o = seg7_font(value_i, HEX_EN);
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Self-timed multiplexed driver for an N-digit common-anode seven-segment display.
// Holds a pending buffer written by the update strobe and an active buffer that
// is refreshed only at frame boundaries, so a frame never mixes old and new data.
module seven_segment_scanner
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 250,
  parameter int HEX_EN       = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic                    update,
  output logic [NUM_DIGITS-1:0]   anode_active,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  // Timing state.
  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BLK_W-1:0] blinkCnt_q, blinkCnt_d;
  logic             blinkPhase_q, blinkPhase_d;

  // Double buffer.
  digit_attr_t [NUM_DIGITS-1:0] pendingBuf_q, pendingBuf_d;
  digit_attr_t [NUM_DIGITS-1:0] activeBuf_q, activeBuf_d;

  // Registered pin drivers.
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]            segments_q, segments_d;
  logic                  dp_q, dp_d;
  logic                  frameDone_q, frameDone_d;

  // Helpers.
  digit_attr_t [NUM_DIGITS-1:0] inputAttr;
  digit_attr_t                  curAttr;
  logic                         slotEnd;
  logic                         frameWrap;
  logic                         curDark;
  logic [6:0]                   fontSeg;

  // Regroup the flat input buses into one record per digit.
  always_comb begin
    inputAttr = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      inputAttr[k].value = digits_in[4*k +: 4];
      inputAttr[k].dp    = dp_in[k];
      inputAttr[k].blank = blank_in[k];
      inputAttr[k].blink = blink_in[k];
    end
  end

  // A slot ends when the divider reaches its last count; the frame ends when the rightmost slot ends.
  always_comb begin
    slotEnd   = (div_q == DIV_LAST);
    frameWrap = slotEnd && (idx_q == '0);
  end

  // Divider, scan index and blink phase advance.
  always_comb begin
    div_d        = slotEnd ? '0 : div_q + 1'b1;
    idx_d        = idx_q;
    blinkCnt_d   = blinkCnt_q;
    blinkPhase_d = blinkPhase_q;
    if (slotEnd) begin
      idx_d = (idx_q == '0) ? IDX_LAST : idx_q - 1'b1;
    end
    if (frameWrap) begin
      if (blinkCnt_q == BLK_LAST) begin
        blinkCnt_d   = '0;
        blinkPhase_d = ~blinkPhase_q;
      end else begin
        blinkCnt_d = blinkCnt_q + 1'b1;
      end
    end
  end

  // Pending takes every update; active only changes at a frame wrap, and an
  // update landing on that very cycle bypasses pending so it is not lost a frame.
  always_comb begin
    pendingBuf_d = update ? inputAttr : pendingBuf_q;
    activeBuf_d  = activeBuf_q;
    if (frameWrap) begin
      activeBuf_d = update ? inputAttr : pendingBuf_q;
    end
  end

  // Select the digit currently being scanned and build its anode pattern.
  always_comb begin
    curAttr = DIGIT_RESET;
    anode_d = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        curAttr = activeBuf_q[k];
      end
      anode_d[k] = (idx_q != IDX_W'(k));
    end
  end

  seven_segment_decoder #(
    .HEX_EN (HEX_EN != 0)
  ) u_decoder (
    .value_i    (curAttr.value),
    .segments_o (fontSeg)
  );

  // Dark digits keep their anode slot so every digit gets the same on-time.
  always_comb begin
    curDark     = curAttr.blank | (curAttr.blink & blinkPhase_q);
    segments_d  = curDark ? SEG_OFF : fontSeg;
    dp_d        = curDark ? 1'b1 : ~curAttr.dp;
    frameDone_d = frameWrap;
  end

  // All state, including the output registers, resets asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q        <= '0;
      idx_q        <= IDX_LAST;
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
      pendingBuf_q <= {NUM_DIGITS{DIGIT_RESET}};
      activeBuf_q  <= {NUM_DIGITS{DIGIT_RESET}};
      anode_q      <= '1;
      segments_q   <= SEG_OFF;
      dp_q         <= 1'b1;
      frameDone_q  <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      blinkCnt_q   <= blinkCnt_d;
      blinkPhase_q <= blinkPhase_d;
      pendingBuf_q <= pendingBuf_d;
      activeBuf_q  <= activeBuf_d;
      anode_q      <= anode_d;
      segments_q   <= segments_d;
      dp_q         <= dp_d;
      frameDone_q  <= frameDone_d;
    end
  end

  assign anode_active = anode_q;
  assign segments     = segments_q;
  assign dp           = dp_q;
  assign frame_done   = frameDone_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: three instances (4-digit hex, 4-digit
// decimal-only, 1-digit fast) against a time-based behavioural model.
module tb_seven_segment_scanner;

  localparam int N     = 4;
  localparam int SD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = N * SD;

  logic clk = 1'b0;
  logic reset;

  logic [15:0] digitsIn;
  logic [3:0]  dpIn, blankIn, blinkIn;
  logic        update;

  logic [3:0] anode, anodeHex0;
  logic [6:0] seg, segHex0;
  logic       dpOut, dpHex0, fd, fdHex0;

  logic [3:0] digits1;
  logic       dp1, blank1, blink1, update1;
  logic       anode1;
  logic [6:0] seg1;
  logic       dpOut1, fd1;

  int testsRun    = 0;
  int testsFailed = 0;

  // Glyph table, active-low, bit6 = a.
  logic [6:0] fontTable [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  // Model state.
  int          edges;
  int          mIdx;
  logic        mPhase, mWrap, mDark;
  logic [3:0]  mVal;
  logic [15:0] pDig, aDig;
  logic [3:0]  pDp, aDp, pBlank, aBlank, pBlink, aBlink;
  logic [3:0]  expAnode;
  logic [6:0]  expSeg, expSegHex0;
  logic        expDp, expFd;

  always #5 clk = ~clk;

  seven_segment_scanner #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .HEX_EN(1)) dut (
    .clk(clk), .reset(reset), .digits_in(digitsIn), .dp_in(dpIn), .blank_in(blankIn),
    .blink_in(blinkIn), .update(update), .anode_active(anode), .segments(seg),
    .dp(dpOut), .frame_done(fd));

  seven_segment_scanner #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .HEX_EN(0)) dutHex0 (
    .clk(clk), .reset(reset), .digits_in(digitsIn), .dp_in(dpIn), .blank_in(blankIn),
    .blink_in(blinkIn), .update(update), .anode_active(anodeHex0), .segments(segHex0),
    .dp(dpHex0), .frame_done(fdHex0));

  seven_segment_scanner #(.NUM_DIGITS(1), .SCAN_DIV(1), .BLINK_FRAMES(BF), .HEX_EN(1)) dut1 (
    .clk(clk), .reset(reset), .digits_in(digits1), .dp_in(dp1), .blank_in(blank1),
    .blink_in(blink1), .update(update1), .anode_active(anode1), .segments(seg1),
    .dp(dpOut1), .frame_done(fd1));

  // Reference model: position in the scan is derived from the number of clock
  // edges since reset; buffers are plain copies of the inputs.
  initial begin : model
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        edges = 0;
        pDig = '0; aDig = '0; pDp = '0; aDp = '0;
        pBlank = '1; aBlank = '1; pBlink = '0; aBlink = '0;
        expAnode = 4'hF; expSeg = 7'h7F; expSegHex0 = 7'h7F; expDp = 1'b1; expFd = 1'b0;
      end else begin
        mIdx   = N - 1 - ((edges / SD) % N);
        mPhase = (((edges / FRAME) / BF) % 2) == 1;
        mWrap  = (edges % FRAME) == FRAME - 1;
        mDark  = aBlank[mIdx] || (aBlink[mIdx] && mPhase);
        mVal   = aDig[mIdx*4 +: 4];
        expAnode   = ~(4'b0001 << mIdx);
        expSeg     = mDark ? 7'h7F : fontTable[mVal];
        expSegHex0 = (mDark || mVal > 4'd9) ? 7'h7F : fontTable[mVal];
        expDp      = mDark ? 1'b1 : ~aDp[mIdx];
        expFd      = mWrap;
        if (mWrap) begin
          if (update) begin
            aDig = digitsIn; aDp = dpIn; aBlank = blankIn; aBlink = blinkIn;
          end else begin
            aDig = pDig; aDp = pDp; aBlank = pBlank; aBlink = pBlink;
          end
        end
        if (update) begin
          pDig = digitsIn; pDp = dpIn; pBlank = blankIn; pBlink = blinkIn;
        end
        edges++;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1; update = 1'b0; digitsIn = '0; dpIn = '0; blankIn = '0; blinkIn = '0;
    update1 = 1'b0; digits1 = '0; dp1 = 1'b0; blank1 = 1'b0; blink1 = 1'b0;
    repeat (2) @(negedge clk);
    testsRun++;
    if ({anode, seg, dpOut, fd} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got anode=%b seg=%h dp=%b fd=%b, want 1111/7f/1/0", anode, seg, dpOut, fd);
    end
    testsRun++;
    if ({anode1, seg1, dpOut1, fd1} !== {1'b1, 7'h7F, 1'b1, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs_1digit: got anode=%b seg=%h dp=%b fd=%b, want 1/7f/1/0", anode1, seg1, dpOut1, fd1);
    end
    reset = 1'b0;
  endtask

  task automatic test_dark_scan();
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      testsRun++;
      if ({anode, seg, dpOut, fd} !== {expAnode, expSeg, expDp, expFd}) begin
        testsFailed++;
        $display("[TB] FAIL dark_scan c=%0d: got %b/%h/%b/%b, want %b/%h/%b/%b",
                 c, anode, seg, dpOut, fd, expAnode, expSeg, expDp, expFd);
      end
    end
  endtask

  task automatic test_static_digits();
    int fdCount;
    @(negedge clk);
    digitsIn = 16'h1234; blankIn = '0; dpIn = 4'b0010; blinkIn = '0; update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    for (int c = 0; c < 3 * FRAME; c++) begin
      @(negedge clk);
      testsRun++;
      if ({anode, seg, dpOut, fd} !== {expAnode, expSeg, expDp, expFd}) begin
        testsFailed++;
        $display("[TB] FAIL static_digits c=%0d: got %b/%h/%b/%b, want %b/%h/%b/%b",
                 c, anode, seg, dpOut, fd, expAnode, expSeg, expDp, expFd);
      end
    end
    fdCount = 0;
    for (int c = 0; c < FRAME; c++) begin
      logic [7:0] want;
      @(negedge clk);
      if (fd) fdCount++;
      case (anode)
        4'b0111: want = {7'h4F, 1'b1};
        4'b1011: want = {7'h12, 1'b1};
        4'b1101: want = {7'h06, 1'b0};
        default: want = {7'h4C, 1'b1};
      endcase
      testsRun++;
      if ({seg, dpOut} !== want) begin
        testsFailed++;
        $display("[TB] FAIL glyph_1234 anode=%b: got seg=%h dp=%b, want seg=%h dp=%b",
                 anode, seg, dpOut, want[7:1], want[0]);
      end
    end
    testsRun++;
    if (fdCount != 1) begin
      testsFailed++;
      $display("[TB] FAIL frame_done_rate: got %0d pulses in %0d cycles, want 1", fdCount, FRAME);
    end
  endtask

  task automatic test_double_update();
    int saw5, saw9;
    for (int c = 0; c < FRAME && (edges % FRAME) != 5; c++) @(negedge clk);
    digitsIn = 16'h5678; update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    repeat (2) @(negedge clk);
    digitsIn = 16'h9999; update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    saw5 = 0; saw9 = 0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      if (anode == 4'b0111 && seg == 7'h24) saw5++;
      if (anode == 4'b0111 && seg == 7'h04) saw9++;
      testsRun++;
      if ({anode, seg, dpOut, fd} !== {expAnode, expSeg, expDp, expFd}) begin
        testsFailed++;
        $display("[TB] FAIL double_update c=%0d: got %b/%h/%b/%b, want %b/%h/%b/%b",
                 c, anode, seg, dpOut, fd, expAnode, expSeg, expDp, expFd);
      end
    end
    testsRun++;
    if (saw5 != 0 || saw9 == 0) begin
      testsFailed++;
      $display("[TB] FAIL last_update_wins: got %0d cycles of 5, %0d of 9, want 0 and >0", saw5, saw9);
    end
  endtask

  task automatic test_blink();
    int litLeft, darkLeft, darkOther;
    @(negedge clk);
    digitsIn = 16'($urandom); blankIn = '0; dpIn = 4'($urandom); blinkIn = 4'b1000; update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      testsRun++;
      if ({anode, seg, dpOut, fd} !== {expAnode, expSeg, expDp, expFd}) begin
        testsFailed++;
        $display("[TB] FAIL blink c=%0d: got %b/%h/%b/%b, want %b/%h/%b/%b",
                 c, anode, seg, dpOut, fd, expAnode, expSeg, expDp, expFd);
      end
    end
    litLeft = 0; darkLeft = 0; darkOther = 0;
    for (int c = 0; c < 4 * FRAME; c++) begin
      @(negedge clk);
      if (anode == 4'b0111) begin
        if (seg == 7'h7F) darkLeft++;
        else litLeft++;
      end else if (seg == 7'h7F) begin
        darkOther++;
      end
    end
    testsRun++;
    if (litLeft != 2 * SD || darkLeft != 2 * SD || darkOther != 0) begin
      testsFailed++;
      $display("[TB] FAIL blink_duty: got lit=%0d dark=%0d otherDark=%0d, want %0d/%0d/0",
               litLeft, darkLeft, darkOther, 2 * SD, 2 * SD);
    end
  endtask

  task automatic test_hex();
    @(negedge clk);
    digitsIn = 16'hAAAA; blankIn = '0; dpIn = '0; blinkIn = '0; update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    repeat (2 * FRAME) @(negedge clk);
    for (int c = 0; c < N; c++) begin
      @(negedge clk);
      testsRun++;
      if (seg !== 7'h08 || segHex0 !== 7'h7F) begin
        testsFailed++;
        $display("[TB] FAIL hex_font: got hex=%h nohex=%h, want 08/7f", seg, segHex0);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      testsRun++;
      if ({anode, seg, dpOut, fd} !== {expAnode, expSeg, expDp, expFd}) begin
        testsFailed++;
        $display("[TB] FAIL random c=%0d: got %b/%h/%b/%b, want %b/%h/%b/%b",
                 c, anode, seg, dpOut, fd, expAnode, expSeg, expDp, expFd);
      end
      testsRun++;
      if ({anodeHex0, segHex0, dpHex0, fdHex0} !== {expAnode, expSegHex0, expDp, expFd}) begin
        testsFailed++;
        $display("[TB] FAIL random_nohex c=%0d: got %b/%h/%b/%b, want %b/%h/%b/%b",
                 c, anodeHex0, segHex0, dpHex0, fdHex0, expAnode, expSegHex0, expDp, expFd);
      end
      update = ($urandom_range(0, 7) == 0);
      if (update) begin
        digitsIn = 16'($urandom);
        dpIn     = 4'($urandom);
        blankIn  = 4'($urandom) & 4'($urandom);
        blinkIn  = 4'($urandom);
      end
    end
    update = 1'b0;
  endtask

  task automatic test_single_digit();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      testsRun++;
      if ({anode1, fd1, seg1} !== {1'b0, 1'b1, 7'h7F}) begin
        testsFailed++;
        $display("[TB] FAIL single_digit_idle c=%0d: got anode=%b fd=%b seg=%h, want 0/1/7f", c, anode1, fd1, seg1);
      end
    end
    digits1 = 4'd5; dp1 = 1'b1; blank1 = 1'b0; blink1 = 1'b0; update1 = 1'b1;
    @(negedge clk);
    update1 = 1'b0;
    @(negedge clk);
    testsRun++;
    if ({anode1, seg1, dpOut1, fd1} !== {1'b0, 7'h24, 1'b0, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL single_digit_value: got %b/%h/%b/%b, want 0/24/0/1", anode1, seg1, dpOut1, fd1);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    digitsIn = 16'h4321; blankIn = '0; dpIn = '0; blinkIn = '0; update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    repeat (FRAME + 6) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    testsRun++;
    if ({anode, seg, dpOut, fd, anode1, seg1} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1, 7'h7F}) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_immediate: got %b/%h/%b/%b 1d=%b/%h, want 1111/7f/1/0 1d=1/7f",
               anode, seg, dpOut, fd, anode1, seg1);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    testsRun++;
    if (anode !== 4'b0111) begin
      testsFailed++;
      $display("[TB] FAIL reset_restart: got anode=%b, want 0111", anode);
    end
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      testsRun++;
      if ({anode, seg, dpOut, fd} !== {expAnode, expSeg, expDp, expFd} || seg !== 7'h7F || seg1 !== 7'h7F) begin
        testsFailed++;
        $display("[TB] FAIL after_reset c=%0d: got %b/%h/%b/%b 1d seg=%h, want %b/7f/%b/%b 1d seg=7f",
                 c, anode, seg, dpOut, fd, seg1, expAnode, expDp, expFd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_dark_scan();
    test_static_digits();
    test_double_update();
    test_blink();
    test_hex();
    test_random();
    test_single_digit();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
